// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// ysyx_22041071_axi_rd_arb_pkg
//   Shared definitions for the IF/MEM read arbiter: FSM state encoding,
//   requester IDs, AXI response codes and the address alignment helper.
//   The optional alignment check is enabled with
//   YSYX_22041071_RD_ARB_ALIGN_CHECK_EN (see ysyx_22041071_axi_rd_arb).
package ysyx_22041071_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Requester index; also the value driven on cpu_id.
  localparam logic ID_IF  = 1'b0;
  localparam logic ID_MEM = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [1:0] size);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = addr_lo[0];
      2'b10:   r = |addr_lo[1:0];
      default: r = |addr_lo[2:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_rr_arb2.sv
// ysyx_22041071_rr_arb2
//   Two-way round-robin grant. With one requester it wins; with both, the
//   one that did not win last time wins. The history updates only when the
//   grant is actually taken (i_accept).
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_req[1:0]   bit0 = IF, bit1 = MEM
//   i_accept     grant consumed this cycle
//   o_grant[1:0] one-hot grant (zero when no request)
module ysyx_22041071_rr_arb2
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last_grant == ID_MEM) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= ID_MEM;
    end else if (i_accept) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ysyx_22041071_axi_rd_arb
//   Merges IF and MEM single-beat read requests into one cpu_* read stream,
//   one transaction outstanding, and routes the returned beat back to the
//   requester that won.
//   Optional: YSYX_22041071_RD_ARB_ALIGN_CHECK_EN rejects misaligned
//   requests locally with SLVERR / zero data and never issues them.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_req_* / mem_req_*         request valid/addr/size in, ready out
//   if_rsp_* / mem_rsp_*         response pulse, data, resp out
//   cpu_ar_valid/id/addr/len/size/ar_ready   address handshake downstream
//   cpu_r_valid/r_data/r_resp    returned beat from downstream
//
//   state | meaning
//   IDLE  | no transaction; ready offered to the round-robin winner
//   ISSUE | cpu_ar_valid high with latched fields, waiting for ar_ready
//   WAIT  | address accepted, waiting for the single read beat
//   RESP  | one-cycle response pulse to the winner
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  input  logic [1:0]        if_req_size,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic [RESP_W-1:0] if_rsp_resp,

  input  logic              mem_req_valid,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [1:0]        mem_req_size,
  output logic              mem_req_ready,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic [RESP_W-1:0] mem_rsp_resp,

  output logic              cpu_ar_valid,
  output logic [ID_W-1:0]   cpu_id,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [LEN_W-1:0]  cpu_len,
  output logic [1:0]        cpu_size,
  input  logic              cpu_ar_ready,
  input  logic              cpu_r_valid,
  input  logic [DATA_W-1:0] cpu_r_data,
  input  logic [RESP_W-1:0] cpu_r_resp
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_who;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_data;
  logic [RESP_W-1:0] r_if_resp;
  logic [RESP_W-1:0] r_mem_resp;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_win;
  logic [ADDR_W-1:0] w_win_addr;
  logic [1:0]        w_win_size;
  logic              w_misalign;
  logic              w_beat;

  assign w_req      = {mem_req_valid, if_req_valid};
  assign w_accept   = (r_state == ST_IDLE) && (|w_req);
  assign w_win      = w_grant[1];
  assign w_win_addr = w_win ? mem_req_addr : if_req_addr;
  assign w_win_size = w_win ? mem_req_size : if_req_size;
  // A beat counts only after the address handshake; strays are dropped.
  assign w_beat     = (r_state == ST_WAIT) && cpu_r_valid;

`ifdef YSYX_22041071_RD_ARB_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(w_win_addr[2:0], w_win_size);
`else
  assign w_misalign = 1'b0;
`endif

  ysyx_22041071_rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    if_req_ready  = 1'b0;
    mem_req_ready = 1'b0;
    cpu_ar_valid  = 1'b0;
    if_rsp_valid  = 1'b0;
    mem_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if_req_ready  = ~w_win;
          mem_req_ready = w_win;
          w_state_nxt   = w_misalign ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cpu_ar_valid = 1'b1;
        if (cpu_ar_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_r_valid) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if_rsp_valid  = (r_who == ID_IF);
        mem_rsp_valid = (r_who == ID_MEM);
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response data is written straight into the winner's holding register,
  // so each master keeps its last response until its next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_who      <= ID_IF;
      r_addr     <= '0;
      r_size     <= '0;
      r_if_data  <= '0;
      r_if_resp  <= '0;
      r_mem_data <= '0;
      r_mem_resp <= '0;
    end else begin
      if (w_accept) begin
        r_who  <= w_win;
        r_addr <= w_win_addr;
        r_size <= w_win_size;
      end
      if (w_accept && w_misalign) begin
        if (w_win == ID_MEM) begin
          r_mem_data <= '0;
          r_mem_resp <= RESP_W'(RESP_SLVERR);
        end else begin
          r_if_data  <= '0;
          r_if_resp  <= RESP_W'(RESP_SLVERR);
        end
      end else if (w_beat) begin
        if (r_who == ID_MEM) begin
          r_mem_data <= cpu_r_data;
          r_mem_resp <= cpu_r_resp;
        end else begin
          r_if_data  <= cpu_r_data;
          r_if_resp  <= cpu_r_resp;
        end
      end
    end
  end

  assign cpu_id       = ID_W'(r_who);
  assign cpu_addr     = r_addr;
  assign cpu_len      = '0;
  assign cpu_size     = r_size;
  assign if_rsp_data  = r_if_data;
  assign if_rsp_resp  = r_if_resp;
  assign mem_rsp_data = r_mem_data;
  assign mem_rsp_resp = r_mem_resp;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
module tb_ysyx_22041071_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req_valid = 1'b0, mem_req_valid = 1'b0;
  logic [63:0] if_req_addr = '0, mem_req_addr = '0;
  logic [1:0]  if_req_size = '0, mem_req_size = '0;
  logic        if_req_ready, mem_req_ready;
  logic        if_rsp_valid, mem_rsp_valid;
  logic [63:0] if_rsp_data, mem_rsp_data;
  logic [1:0]  if_rsp_resp, mem_rsp_resp;
  logic        cpu_ar_valid;
  logic [3:0]  cpu_id;
  logic [63:0] cpu_addr;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size;
  logic        cpu_ar_ready = 1'b0, cpu_r_valid = 1'b0;
  logic [63:0] cpu_r_data = '0;
  logic [1:0]  cpu_r_resp = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_arb dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_size(if_req_size),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .if_rsp_resp(if_rsp_resp),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_resp(mem_rsp_resp),
    .cpu_ar_valid(cpu_ar_valid), .cpu_id(cpu_id), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
    .cpu_size(cpu_size), .cpu_ar_ready(cpu_ar_ready), .cpu_r_valid(cpu_r_valid),
    .cpu_r_data(cpu_r_data), .cpu_r_resp(cpu_r_resp)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, whether its address and
  // data phases are done, and what each master last received.
  bit          m_last = 1'b1;
  bit          m_busy, m_sent, m_due, m_who;
  logic [63:0] m_addr, m_if_d, m_mem_d;
  logic [1:0]  m_size, m_if_r, m_mem_r;
  bit          e_if_rdy, e_mem_rdy, e_arv;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_last = 1'b1; m_busy = 0; m_sent = 0; m_due = 0; m_who = 0;
        m_addr = '0; m_size = '0; m_if_d = '0; m_if_r = '0; m_mem_d = '0; m_mem_r = '0;
      end else begin
        e_if_rdy  = !m_busy && if_req_valid && (!mem_req_valid || m_last == 1'b1);
        e_mem_rdy = !m_busy && mem_req_valid && (!if_req_valid || m_last == 1'b0);
        e_arv     = m_busy && !m_sent && !m_due;
        chk("if_req_ready",  if_req_ready,  e_if_rdy);
        chk("mem_req_ready", mem_req_ready, e_mem_rdy);
        chk("cpu_ar_valid",  cpu_ar_valid,  e_arv);
        chk("cpu_id",        cpu_id,        {3'b0, m_who});
        chk("cpu_addr",      cpu_addr,      m_addr);
        chk("cpu_len",       cpu_len,       64'd0);
        chk("cpu_size",      cpu_size,      m_size);
        chk("if_rsp_valid",  if_rsp_valid,  m_due && !m_who);
        chk("mem_rsp_valid", mem_rsp_valid, m_due && m_who);
        chk("if_rsp_data",   if_rsp_data,   m_if_d);
        chk("if_rsp_resp",   if_rsp_resp,   m_if_r);
        chk("mem_rsp_data",  mem_rsp_data,  m_mem_d);
        chk("mem_rsp_resp",  mem_rsp_resp,  m_mem_r);
        if (m_due) begin
          m_busy = 0; m_due = 0;
        end else if (e_arv) begin
          if (cpu_ar_ready) m_sent = 1;
        end else if (m_busy) begin
          if (cpu_r_valid) begin
            if (m_who) begin m_mem_d = cpu_r_data; m_mem_r = cpu_r_resp; end
            else       begin m_if_d  = cpu_r_data; m_if_r  = cpu_r_resp; end
            m_due = 1;
          end
        end else if (e_if_rdy || e_mem_rdy) begin
          m_who  = e_mem_rdy;
          m_last = m_who;
          m_busy = 1; m_sent = 0;
          m_addr = m_who ? mem_req_addr : if_req_addr;
          m_size = m_who ? mem_req_size : if_req_size;
`ifdef YSYX_22041071_RD_ARB_ALIGN_CHECK_EN
          if ((m_addr & ((64'd1 << m_size) - 64'd1)) != 64'd0) begin
            if (m_who) begin m_mem_d = '0; m_mem_r = 2'b10; end
            else       begin m_if_d  = '0; m_if_r  = 2'b10; end
            m_due = 1;
          end
`endif
        end
      end
    end
  end

  // Snapshot of DUT outputs taken late in each cycle by tick().
  logic        s_if_rdy, s_mem_rdy, s_hs, s_arv, s_if_rv, s_mem_rv;
  logic [63:0] s_addr, s_if_rd, s_mem_rd;
  logic [1:0]  s_size, s_if_rr, s_mem_rr;
  logic [3:0]  s_id;
  logic [7:0]  s_len;
  bit          slave_auto = 0;
  bit          rearm = 0;
  int          grants[32];
  int          n_g = 0;

  // Starts and ends at posedge+1. Requesters drop valid after acceptance
  // (or move to the next address when rearm is set); the auto slave
  // accepts every address and returns the beat the following cycle.
  task automatic tick();
    #3;
    s_if_rdy = if_req_ready; s_mem_rdy = mem_req_ready;
    s_hs = cpu_ar_valid && cpu_ar_ready;
    s_arv = cpu_ar_valid; s_addr = cpu_addr; s_size = cpu_size; s_id = cpu_id; s_len = cpu_len;
    s_if_rv = if_rsp_valid; s_if_rd = if_rsp_data; s_if_rr = if_rsp_resp;
    s_mem_rv = mem_rsp_valid; s_mem_rd = mem_rsp_data; s_mem_rr = mem_rsp_resp;
    @(posedge clk); #1;
    if (s_if_rdy) begin
      if (n_g < 32) grants[n_g] = 0;
      n_g++;
      if (rearm) if_req_addr = if_req_addr + 64'd8; else if_req_valid = 0;
    end
    if (s_mem_rdy) begin
      if (n_g < 32) grants[n_g] = 1;
      n_g++;
      if (rearm) mem_req_addr = mem_req_addr + 64'd8; else mem_req_valid = 0;
    end
    if (slave_auto) begin
      cpu_ar_ready = 1;
      cpu_r_valid  = s_hs;
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    if_req_valid = 0; mem_req_valid = 0; cpu_ar_ready = 0; cpu_r_valid = 0;
    slave_auto = 0; rearm = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic wait_rsp(input bit is_mem, input int bound);
    bit got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      tick();
      if (is_mem ? s_mem_rv : s_if_rv) got = 1;
    end
    chk("rsp_arrived", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    do_reset();
    #1;
    chk("rst_cpu_ar_valid", cpu_ar_valid, 0);
    chk("rst_cpu_addr", cpu_addr, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    #1;  // back to posedge+1 not needed; realign on next edge
    @(posedge clk); #1;

    // IF only, 8-byte read at 0x8000_0000
    slave_auto = 1; cpu_ar_ready = 1;
    cpu_r_data = 64'h1122334455667788; cpu_r_resp = 2'b00;
    if_req_valid = 1; if_req_addr = 64'h8000_0000; if_req_size = 2'b11;
    tick();
    chk("t1_if_ready", s_if_rdy, 1);
    tick();
    chk("t1_ar_valid", s_arv, 1);
    chk("t1_cpu_addr", s_addr, 64'h8000_0000);
    chk("t1_cpu_id", s_id, 0);
    chk("t1_cpu_len", s_len, 0);
    chk("t1_cpu_size", s_size, 2'b11);
    wait_rsp(0, 20);
    chk("t1_rsp_data", s_if_rd, 64'h1122334455667788);
    chk("t1_rsp_resp", s_if_rr, 2'b00);
    chk("t1_mem_quiet", s_mem_rv, 0);
    tick();

    // Both requesters valid continuously: grants alternate, IF first.
    do_reset();
    slave_auto = 1; cpu_ar_ready = 1; cpu_r_data = 64'h0BAD_F00D_0000_0001;
    rearm = 1; n_g = 0;
    if_req_valid = 1;  if_req_addr = 64'h8000_2000;  if_req_size = 2'b11;
    mem_req_valid = 1; mem_req_addr = 64'h8000_3000; mem_req_size = 2'b11;
    for (int k = 0; k < 200 && n_g < 16; k++) tick();
    chk("rr_grant_count", (n_g >= 16), 1);
    for (int i = 0; i < 16; i++) chk($sformatf("rr_grant_%0d", i), grants[i], i % 2);
    rearm = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (!if_req_valid && !mem_req_valid) done = 1;
    end
    chk("rr_drain", done, 1);
    repeat (6) tick();

    // Address channel stalled for 5 cycles; IF request waits meanwhile.
    do_reset();
    mem_req_valid = 1; mem_req_addr = 64'h8000_0040; mem_req_size = 2'b10;
    tick();
    chk("st_mem_ready", s_mem_rdy, 1);
    if_req_valid = 1; if_req_addr = 64'h8000_0100; if_req_size = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("st_ar_valid_%0d", i), s_arv, 1);
      chk($sformatf("st_addr_%0d", i), s_addr, 64'h8000_0040);
      chk($sformatf("st_size_%0d", i), s_size, 2'b10);
      chk($sformatf("st_no_ready_%0d", i), s_if_rdy | s_mem_rdy, 0);
    end
    cpu_ar_ready = 1;
    tick();
    cpu_ar_ready = 0; cpu_r_valid = 1; cpu_r_data = 64'h0000_0000_DEAD_BEEF; cpu_r_resp = 2'b00;
    tick();
    cpu_r_valid = 0;
    tick();
    chk("st_mem_rsp", s_mem_rv, 1);
    chk("st_mem_data", s_mem_rd, 64'h0000_0000_DEAD_BEEF);
    slave_auto = 1; cpu_ar_ready = 1; cpu_r_data = 64'h5555_6666_7777_8888;
    wait_rsp(0, 20);
    chk("st_if_data", s_if_rd, 64'h5555_6666_7777_8888);
    tick();

    // Stray beats in IDLE and ISSUE, then MEM read returning SLVERR.
    slave_auto = 0; cpu_ar_ready = 0;
    cpu_r_valid = 1; cpu_r_data = 64'hFFFF_0000_FFFF_0000; cpu_r_resp = 2'b11;
    tick();
    cpu_r_valid = 0;
    tick();
    chk("sr_idle_no_rsp", s_if_rv | s_mem_rv, 0);
    mem_req_valid = 1; mem_req_addr = 64'h8000_1004; mem_req_size = 2'b10;
    tick();
    chk("sr_mem_ready", s_mem_rdy, 1);
    cpu_r_valid = 1; cpu_ar_ready = 1;
    tick();
    chk("sr_issue_hs", s_hs, 1);
    cpu_r_valid = 0; cpu_ar_ready = 0;
    tick();
    chk("sr_wait_no_rsp", s_if_rv | s_mem_rv, 0);
    cpu_r_valid = 1; cpu_r_data = 64'h0000_0000_CAFE_0000; cpu_r_resp = 2'b10;
    tick();
    cpu_r_valid = 0;
    tick();
    chk("sr_mem_rsp", s_mem_rv, 1);
    chk("sr_mem_resp", s_mem_rr, 2'b10);
    chk("sr_mem_data", s_mem_rd, 64'h0000_0000_CAFE_0000);
    tick();
    chk("sr_hold_resp", s_mem_rr, 2'b10);

    // Reset while waiting for the beat.
    if_req_valid = 1; if_req_addr = 64'h8000_0200; if_req_size = 2'b11;
    tick();
    cpu_ar_ready = 1;
    tick();
    cpu_ar_ready = 0;
    reset_n = 0;
    #1;
    chk("ar_cpu_ar_valid", cpu_ar_valid, 0);
    chk("ar_cpu_addr", cpu_addr, 0);
    chk("ar_if_rsp_valid", if_rsp_valid, 0);
    chk("ar_if_rsp_data", if_rsp_data, 0);
    chk("ar_mem_rsp_resp", mem_rsp_resp, 0);
    @(posedge clk); #1;
    reset_n = 1;
    cpu_r_valid = 1; cpu_r_data = 64'h1234; cpu_r_resp = 2'b00;
    tick();
    cpu_r_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_no_rsp_%0d", i), s_if_rv | s_mem_rv, 0);
    end

`ifdef YSYX_22041071_RD_ARB_ALIGN_CHECK_EN
    mem_req_valid = 1; mem_req_addr = 64'h8000_0002; mem_req_size = 2'b10;
    tick();
    chk("al_mem_ready", s_mem_rdy, 1);
    tick();
    chk("al_no_ar", s_arv, 0);
    chk("al_mem_rsp", s_mem_rv, 1);
    chk("al_mem_resp", s_mem_rr, 2'b10);
    chk("al_mem_data", s_mem_rd, 0);
    tick();
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
